// File: rtl/n2_com_dp_32x84_qctl.sv
// Queue controller that drives a 32x84 two-port register-file array as a push/pop FIFO.
// A 2-entry skid buffer absorbs the array's one-cycle registered read latency.
module n2_com_dp_32x84_qctl #(
  parameter int WIDTH = 84,
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic             l2clk,
  input  logic             rst_l,
  input  logic             flush,
  input  logic             push_vld,
  input  logic [WIDTH-1:0] push_data,
  output logic             push_rdy,
  output logic             pop_vld,
  output logic [WIDTH-1:0] pop_data,
  input  logic             pop_rdy,
  output logic [5:0]       entry_cnt,
  output logic             wr_en,
  output logic [AW-1:0]    wr_adr,
  output logic [WIDTH-1:0] din,
  output logic             rd_en,
  output logic [AW-1:0]    rd_adr,
  input  logic [WIDTH-1:0] dout
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [AW:0]      arr_cnt;
  logic [1:0]       skid_cnt_q, skid_cnt_d, cnt_after_pop;
  logic [WIDTH-1:0] skid_q [2];
  logic [WIDTH-1:0] skid_d [2];
  logic             rd_inflight_q;
  logic             active_q;
  logic             push_fire, pop_fire;
  logic [2:0]       occ;

  // Pointers carry a wrap bit, so the modulo difference distinguishes empty (0) from full (32).
  assign arr_cnt   = wr_ptr_q - rd_ptr_q;

  assign push_rdy  = active_q & ~flush & (arr_cnt < FULL_CNT);
  assign push_fire = push_vld & push_rdy;
  assign wr_en     = push_fire;
  assign wr_adr    = wr_ptr_q[AW-1:0];
  assign din       = push_data;

  assign pop_vld   = (skid_cnt_q != 2'd0);
  assign pop_data  = pop_vld ? skid_q[0] : '0;
  assign pop_fire  = pop_vld & pop_rdy;

  // Only issue a read if the skid will have a free slot when its data lands.
  assign occ       = {1'b0, skid_cnt_q} + {2'b0, rd_inflight_q} - {2'b0, pop_fire};
  assign rd_en     = ~flush & (arr_cnt != '0) & (occ <= 3'd1);
  assign rd_adr    = rd_ptr_q[AW-1:0];

  assign entry_cnt = arr_cnt + {{(AW-1){1'b0}}, skid_cnt_q} + {{AW{1'b0}}, rd_inflight_q};

  // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
  always_comb begin
    wr_ptr_d      = wr_ptr_q + {{AW{1'b0}}, push_fire};
    rd_ptr_d      = rd_ptr_q + {{AW{1'b0}}, rd_en};
    skid_d[0]     = skid_q[0];
    skid_d[1]     = skid_q[1];
    cnt_after_pop = skid_cnt_q - {1'b0, pop_fire};
    skid_cnt_d    = cnt_after_pop + {1'b0, rd_inflight_q};

    if (pop_fire) skid_d[0] = skid_q[1];
    if (rd_inflight_q) begin
      if (cnt_after_pop == 2'd0) skid_d[0] = dout;
      else                       skid_d[1] = dout;
    end

    // Flush drops the skid and any in-flight read; the read side catches up to the write side.
    if (flush) begin
      rd_ptr_d   = wr_ptr_q;
      skid_cnt_d = 2'd0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge l2clk or negedge rst_l) begin
    if (!rst_l) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      skid_cnt_q    <= 2'd0;
      rd_inflight_q <= 1'b0;
      active_q      <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      skid_cnt_q    <= skid_cnt_d;
      rd_inflight_q <= rd_en;
      active_q      <= 1'b1;
    end
  end

  // NOTE: skid data storage has no reset; skid_cnt_q qualifies it and pop_data is masked when empty.
  always_ff @(posedge l2clk) begin
    skid_q[0] <= skid_d[0];
    skid_q[1] <= skid_d[1];
  end

endmodule

// File: tb/tb_n2_com_dp_32x84_qctl.sv
// Directed and random bench for the 32x84 queue controller, with a behavioural
// model of the two-port array (registered dout, one cycle after rd_en).
module tb_n2_com_dp_32x84_qctl;

  logic        l2clk = 1'b0;
  logic        rst_l = 1'b0;
  logic        flush = 1'b0;
  logic        push_vld = 1'b0;
  logic [83:0] push_data = '0;
  logic        push_rdy;
  logic        pop_vld;
  logic [83:0] pop_data;
  logic        pop_rdy = 1'b0;
  logic [5:0]  entry_cnt;
  logic        wr_en;
  logic [4:0]  wr_adr;
  logic [83:0] din;
  logic        rd_en;
  logic [4:0]  rd_adr;
  logic [83:0] dout = '0;

  int n_cmp = 0;
  int n_bad = 0;
  int hazards = 0;
  int ra_exp = 0;

  logic [83:0] mem [32];

  n2_com_dp_32x84_qctl dut (
    .l2clk(l2clk), .rst_l(rst_l), .flush(flush),
    .push_vld(push_vld), .push_data(push_data), .push_rdy(push_rdy),
    .pop_vld(pop_vld), .pop_data(pop_data), .pop_rdy(pop_rdy),
    .entry_cnt(entry_cnt),
    .wr_en(wr_en), .wr_adr(wr_adr), .din(din),
    .rd_en(rd_en), .rd_adr(rd_adr), .dout(dout)
  );

  always #5 l2clk = ~l2clk;

  always @(posedge l2clk) begin
    if (wr_en) mem[wr_adr] <= din;
    if (rd_en) dout <= mem[rd_adr];
  end

  // Drive inputs on the falling edge, then let combinational outputs settle before the tasks look.
  task automatic step(input logic pv, input logic [83:0] pd, input logic pr, input logic fl);
    @(negedge l2clk);
    push_vld = pv; push_data = pd; pop_rdy = pr; flush = fl;
    #1;
    if (wr_en && rd_en && wr_adr == rd_adr) hazards++;
  endtask

  task automatic do_reset();
    @(negedge l2clk);
    rst_l = 1'b0; push_vld = 1'b0; pop_rdy = 1'b0; flush = 1'b0;
    @(negedge l2clk);
    rst_l = 1'b1;
    ra_exp = 0;
    step(0, '0, 0, 0);
  endtask

  task automatic test_reset();
    @(negedge l2clk);
    rst_l = 1'b0; push_vld = 1'b1; push_data = 84'h3; pop_rdy = 1'b1;
    #1;
    n_cmp++;
    if ({push_rdy, pop_vld, entry_cnt, wr_en, rd_en, wr_adr, rd_adr} !== 20'h0) begin
      n_bad++;
      $display("FAIL reset_outputs: got rdy=%b vld=%b cnt=%0d wen=%b ren=%b wa=%0d ra=%0d want all 0",
               push_rdy, pop_vld, entry_cnt, wr_en, rd_en, wr_adr, rd_adr);
    end
    n_cmp++;
    if (pop_data !== 84'h0) begin
      n_bad++; $display("FAIL reset_pop_data: got %h want 0", pop_data);
    end
    @(negedge l2clk);
    rst_l = 1'b1; push_vld = 1'b0; pop_rdy = 1'b0;
    step(0, '0, 0, 0);
    n_cmp++;
    if (push_rdy !== 1'b1) begin
      n_bad++; $display("FAIL reset_release_rdy: got %b want 1", push_rdy);
    end
  endtask

  task automatic test_single();
    do_reset();
    step(1, 84'hA5, 1, 0);
    n_cmp++;
    if ({wr_en, wr_adr, entry_cnt} !== {1'b1, 5'd0, 6'd0}) begin
      n_bad++; $display("FAIL single_N: got wen=%b wa=%0d cnt=%0d want 1 0 0", wr_en, wr_adr, entry_cnt);
    end
    step(0, '0, 1, 0);
    n_cmp++;
    if ({rd_en, rd_adr, entry_cnt, pop_vld} !== {1'b1, 5'd0, 6'd1, 1'b0}) begin
      n_bad++; $display("FAIL single_N1: got ren=%b ra=%0d cnt=%0d vld=%b want 1 0 1 0", rd_en, rd_adr, entry_cnt, pop_vld);
    end
    step(0, '0, 1, 0);
    n_cmp++;
    if ({rd_en, entry_cnt, pop_vld} !== {1'b0, 6'd1, 1'b0}) begin
      n_bad++; $display("FAIL single_N2: got ren=%b cnt=%0d vld=%b want 0 1 0", rd_en, entry_cnt, pop_vld);
    end
    step(0, '0, 1, 0);
    n_cmp++;
    if ({pop_vld, pop_data} !== {1'b1, 84'hA5}) begin
      n_bad++; $display("FAIL single_N3: got vld=%b data=%h want 1 a5", pop_vld, pop_data);
    end
    step(0, '0, 1, 0);
    n_cmp++;
    if ({pop_vld, entry_cnt} !== {1'b0, 6'd0}) begin
      n_bad++; $display("FAIL single_N4: got vld=%b cnt=%0d want 0 0", pop_vld, entry_cnt);
    end
  endtask

  // Fill from empty with no pops: 34 back-to-back accepts, then push_rdy must drop.
  task automatic test_fill(input int base);
    for (int i = 0; i < 34; i++) begin
      step(1, 84'(base + i), 0, 0);
      n_cmp++;
      if ({push_rdy, wr_en, wr_adr} !== {1'b1, 1'b1, 5'(base + i)}) begin
        n_bad++; $display("FAIL fill_accept[%0d]: got rdy=%b wen=%b wa=%0d want 1 1 %0d",
                          i, push_rdy, wr_en, wr_adr, (base + i) % 32);
      end
      if (rd_en) begin
        n_cmp++;
        if (rd_adr !== 5'(ra_exp)) begin
          n_bad++; $display("FAIL fill_rd_adr: got %0d want %0d", rd_adr, ra_exp % 32);
        end
        ra_exp++;
      end
    end
    for (int i = 0; i < 3; i++) begin
      step(1, 84'hBAD, 0, 0);
      n_cmp++;
      if ({push_rdy, wr_en, entry_cnt} !== {1'b0, 1'b0, 6'd34}) begin
        n_bad++; $display("FAIL fill_full: got rdy=%b wen=%b cnt=%0d want 0 0 34", push_rdy, wr_en, entry_cnt);
      end
    end
  endtask

  task automatic test_drain(input int base);
    int got = 0;
    int gaps = 0;
    for (int c = 0; c < 60 && got < 34; c++) begin
      step(0, '0, 1, 0);
      if (rd_en) begin
        n_cmp++;
        if (rd_adr !== 5'(ra_exp)) begin
          n_bad++; $display("FAIL drain_rd_adr: got %0d want %0d", rd_adr, ra_exp % 32);
        end
        ra_exp++;
      end
      if (pop_vld) begin
        n_cmp++;
        if (pop_data !== 84'(base + got)) begin
          n_bad++; $display("FAIL drain_order: got %h want %h", pop_data, 84'(base + got));
        end
        got++;
      end else if (got > 0) gaps++;
    end
    n_cmp++;
    if (got != 34 || gaps != 0) begin
      n_bad++; $display("FAIL drain_count: got pops=%0d gaps=%0d want 34 0", got, gaps);
    end
    step(0, '0, 1, 0);
    n_cmp++;
    if (entry_cnt !== 6'd0) begin
      n_bad++; $display("FAIL drain_empty: got cnt=%0d want 0", entry_cnt);
    end
  endtask

  task automatic test_back_to_back();
    int exp = 1;
    do_reset();
    for (int c = 0; c < 110; c++) begin
      step(c < 100, 84'(c + 1), 1, 0);
      if (c >= 3 && c <= 102) begin
        n_cmp++;
        if (pop_vld !== 1'b1) begin
          n_bad++; $display("FAIL stream_bubble[%0d]: got vld=%b want 1", c, pop_vld);
        end
      end
      if (pop_vld) begin
        n_cmp++;
        if (pop_data !== 84'(exp)) begin
          n_bad++; $display("FAIL stream_data: got %h want %h", pop_data, 84'(exp));
        end
        exp++;
      end
      if (c >= 3 && c < 100) begin
        n_cmp++;
        if (entry_cnt !== 6'd3) begin
          n_bad++; $display("FAIL stream_cnt[%0d]: got %0d want 3", c, entry_cnt);
        end
      end
    end
    n_cmp++;
    if (exp != 101) begin
      n_bad++; $display("FAIL stream_total: got %0d want 100", exp - 1);
    end
  endtask

  task automatic test_random();
    logic [83:0] q [$];
    logic [83:0] d, e;
    int held = 0;
    do_reset();
    hazards = 0;
    for (int c = 0; c < 1100; c++) begin
      d = {20'($urandom), $urandom, $urandom};
      step(c < 1000 ? 1'($urandom) : 1'b0, d, c < 1000 ? 1'($urandom) : 1'b1, 0);
      n_cmp++;
      if (entry_cnt !== 6'(held)) begin
        n_bad++; $display("FAIL rand_cnt[%0d]: got %0d want %0d", c, entry_cnt, held);
      end
      if (push_vld && push_rdy) begin
        q.push_back(d); held++;
      end
      if (pop_vld && pop_rdy) begin
        e = (q.size() > 0) ? q.pop_front() : 84'hX;
        n_cmp++;
        if (pop_data !== e) begin
          n_bad++; $display("FAIL rand_order[%0d]: got %h want %h", c, pop_data, e);
        end
        held--;
      end
    end
    n_cmp++;
    if (q.size() != 0 || hazards != 0) begin
      n_bad++; $display("FAIL rand_end: got left=%0d hazards=%0d want 0 0", q.size(), hazards);
    end
  endtask

  task automatic await_pop(input logic [83:0] want, input string name);
    bit seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      step(0, '0, 1, 0);
      if (pop_vld) begin
        seen = 1;
        n_cmp++;
        if (pop_data !== want) begin
          n_bad++; $display("FAIL %s_data: got %h want %h", name, pop_data, want);
        end
      end
    end
    n_cmp++;
    if (!seen) begin
      n_bad++; $display("FAIL %s_timeout: got no pop_vld want %h", name, want);
    end
  endtask

  task automatic test_flush();
    do_reset();
    for (int i = 0; i < 10; i++) step(1, 84'h100 + 84'(i), 0, 0);
    for (int i = 0; i < 3; i++) step(0, '0, 0, 0);
    step(0, '0, 1, 0);
    n_cmp++;
    if ({pop_vld, pop_data, rd_en} !== {1'b1, 84'h100, 1'b1}) begin
      n_bad++; $display("FAIL flush_pre: got vld=%b data=%h ren=%b want 1 100 1", pop_vld, pop_data, rd_en);
    end
    step(1, 84'hDEAD, 0, 1);
    n_cmp++;
    if ({push_rdy, wr_en, rd_en} !== 3'b000) begin
      n_bad++; $display("FAIL flush_cycle: got rdy=%b wen=%b ren=%b want 0 0 0", push_rdy, wr_en, rd_en);
    end
    step(0, '0, 0, 0);
    n_cmp++;
    if ({pop_vld, entry_cnt} !== {1'b0, 6'd0}) begin
      n_bad++; $display("FAIL flush_after: got vld=%b cnt=%0d want 0 0", pop_vld, entry_cnt);
    end
    step(1, 84'h1, 1, 0);
    n_cmp++;
    if (wr_en !== 1'b1) begin
      n_bad++; $display("FAIL flush_repush: got wen=%b want 1", wr_en);
    end
    await_pop(84'h1, "flush_pop");
    step(0, '0, 1, 0);
    n_cmp++;
    if (entry_cnt !== 6'd0) begin
      n_bad++; $display("FAIL flush_final_cnt: got %0d want 0", entry_cnt);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 6; i++) step(1, 84'h50 + 84'(i), i > 3, 0);
    @(negedge l2clk);
    #2 rst_l = 1'b0;
    #1;
    n_cmp++;
    if ({push_rdy, pop_vld, entry_cnt, wr_en, rd_en, wr_adr, rd_adr} !== 20'h0 || pop_data !== 84'h0) begin
      n_bad++;
      $display("FAIL midreset_outputs: got rdy=%b vld=%b cnt=%0d wen=%b ren=%b wa=%0d ra=%0d data=%h want all 0",
               push_rdy, pop_vld, entry_cnt, wr_en, rd_en, wr_adr, rd_adr, pop_data);
    end
    push_vld = 1'b0; pop_rdy = 1'b0;
    @(negedge l2clk);
    rst_l = 1'b1;
    step(0, '0, 0, 0);
    step(1, 84'h7, 1, 0);
    n_cmp++;
    if ({wr_en, wr_adr} !== {1'b1, 5'd0}) begin
      n_bad++; $display("FAIL midreset_repush: got wen=%b wa=%0d want 1 0", wr_en, wr_adr);
    end
    await_pop(84'h7, "midreset_pop");
  endtask

  initial begin
    test_reset();
    test_single();
    do_reset();
    test_fill(0);
    test_drain(0);
    test_fill(34);
    test_drain(34);
    test_back_to_back();
    test_random();
    test_flush();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
